// File: rtl/game_clock_ctrl.sv
// Countdown game clock: one-second prescaler, IDLE/RUN/PAUSE/EXPIRED sequencing,
// saturating bonus time, BCD digit outputs and a single-cycle time-up pulse.
module game_clock_ctrl #(
  parameter int unsigned TICK_DIV  = 12_500_000,
  parameter int unsigned INIT_SEC  = 99,
  parameter int unsigned WARN_SEC  = 10,
  parameter int unsigned BONUS_SEC = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       warn,
  output logic       sec_tick,
  output logic       time_up
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [6:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          time_up_q, time_up_d;
  logic [6:0]    dec;

  function automatic logic [6:0] sat_add(input logic [6:0] base);
    logic [7:0] sum;
    sum = {1'b0, base} + 8'(BONUS_SEC);
    return (sum > 8'd99) ? 7'd99 : sum[6:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 7'(INIT_SEC);
      presc_q   <= '0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      time_up_q <= time_up_d;
    end
  end

  assign sec_tick = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign dec      = count_q - 7'd1;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    time_up_d = 1'b0;
    if (start) begin
      state_d = RUN;
      count_d = 7'(INIT_SEC);
      presc_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (sec_tick) begin
            // Tick always lands; pause outranks bonus, and a bonus keeps the count >= 1.
            presc_d = '0;
            count_d = dec;
            if (pause) begin
              if (dec == '0) begin
                state_d   = EXPIRED;
                time_up_d = 1'b1;
              end else begin
                state_d = PAUSE;
              end
            end else if (bonus) begin
              count_d = sat_add(dec);
            end else if (dec == '0) begin
              state_d   = EXPIRED;
              time_up_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
            if (pause)      state_d = PAUSE;
            else if (bonus) count_d = sat_add(count_q);
          end
        end
        PAUSE: begin
          if (pause)      state_d = RUN;
          else if (bonus) count_d = sat_add(count_q);
        end
        EXPIRED: count_d = '0;
        default: ;
      endcase
    end
  end

  assign sec_tens = 4'(count_q / 7'd10);
  assign sec_ones = 4'(count_q % 7'd10);
  assign running  = (state_q == RUN);
  assign warn     = ((state_q == RUN) || (state_q == PAUSE)) &&
                    (count_q != '0) && (count_q <= 7'(WARN_SEC));
  assign time_up  = time_up_q;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Directed bench for game_clock_ctrl: vector table for the main sequences plus
// hand-written saturation, bonus-on-tick and asynchronous reset sequences.
module tb_game_clock_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, pause, bonus;
  logic [3:0] sec_tens, sec_ones;
  logic       running, warn, sec_tick, time_up;

  int n_checks = 0;
  int n_fail   = 0;

  game_clock_ctrl #(
    .TICK_DIV (4),
    .INIT_SEC (3),
    .WARN_SEC (2),
    .BONUS_SEC(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pause   (pause),
    .bonus   (bonus),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .running (running),
    .warn    (warn),
    .sec_tick(sec_tick),
    .time_up (time_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic st, pa, bo;
    int   tens, ones;
    logic run, wrn, tick, tu;
  } vec_t;

  vec_t vecs[34];

  function automatic logic [11:0] pk(input int t, input int o, input logic r,
                                     input logic w, input logic k, input logic u);
    return {4'(t), 4'(o), r, w, k, u};
  endfunction

  task automatic chk(input string nm, input logic [11:0] exp);
    logic [11:0] act;
    act = {sec_tens, sec_ones, running, warn, sec_tick, time_up};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got tens/ones/run/warn/tick/tu=%h/%h/%b%b%b%b required %h/%h/%b%b%b%b",
               nm, $time, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive inputs for one cycle and check the outputs seen during that cycle.
  task automatic step(input logic st, input logic pa, input logic bo,
                      input logic [11:0] exp, input string nm);
    @(negedge clk);
    start = st; pause = pa; bonus = bo;
    #1;
    chk(nm, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; bonus = 1'b0;

    //         n   st pa bo tens ones run wrn tik tu
    vecs[0]  = '{1,  0, 0, 0, 0, 3, 0, 0, 0, 0};  // idle after reset
    vecs[1]  = '{1,  1, 0, 0, 0, 3, 0, 0, 0, 0};  // start pulse
    vecs[2]  = '{3,  0, 0, 0, 0, 3, 1, 0, 0, 0};
    vecs[3]  = '{1,  0, 0, 0, 0, 3, 1, 0, 1, 0};  // 4th RUN cycle tick
    vecs[4]  = '{3,  0, 0, 0, 0, 2, 1, 1, 0, 0};
    vecs[5]  = '{1,  0, 0, 0, 0, 2, 1, 1, 1, 0};  // 8th
    vecs[6]  = '{3,  0, 0, 0, 0, 1, 1, 1, 0, 0};
    vecs[7]  = '{1,  0, 0, 0, 0, 1, 1, 1, 1, 0};  // 12th
    vecs[8]  = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 1};  // time_up on 13th
    vecs[9]  = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{1,  0, 1, 0, 0, 0, 0, 0, 0, 0};  // pause ignored in EXPIRED
    vecs[11] = '{1,  0, 0, 1, 0, 0, 0, 0, 0, 0};  // bonus ignored in EXPIRED
    vecs[12] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{1,  1, 0, 0, 0, 0, 0, 0, 0, 0};  // restart
    vecs[14] = '{1,  0, 0, 0, 0, 3, 1, 0, 0, 0};
    vecs[15] = '{1,  0, 1, 0, 0, 3, 1, 0, 0, 0};  // pause on 2nd RUN cycle
    vecs[16] = '{10, 0, 0, 0, 0, 3, 0, 0, 0, 0};  // held, no tick
    vecs[17] = '{1,  0, 1, 0, 0, 3, 0, 0, 0, 0};  // resume
    vecs[18] = '{1,  0, 0, 0, 0, 3, 1, 0, 0, 0};
    vecs[19] = '{1,  0, 0, 0, 0, 3, 1, 0, 1, 0};  // tick 2 cycles after resume
    vecs[20] = '{1,  0, 1, 0, 0, 2, 1, 1, 0, 0};  // pause again
    vecs[21] = '{1,  0, 0, 0, 0, 2, 0, 1, 0, 0};  // warn held in PAUSE
    vecs[22] = '{1,  1, 1, 0, 0, 2, 0, 1, 0, 0};  // start beats pause
    vecs[23] = '{3,  0, 0, 0, 0, 3, 1, 0, 0, 0};
    vecs[24] = '{1,  0, 0, 0, 0, 3, 1, 0, 1, 0};  // prescaler was cleared
    vecs[25] = '{1,  0, 0, 0, 0, 2, 1, 1, 0, 0};
    vecs[26] = '{2,  0, 0, 0, 0, 2, 1, 1, 0, 0};
    vecs[27] = '{1,  0, 1, 0, 0, 2, 1, 1, 1, 0};  // pause on tick cycle
    vecs[28] = '{2,  0, 0, 0, 0, 1, 0, 1, 0, 0};
    vecs[29] = '{1,  0, 1, 0, 0, 1, 0, 1, 0, 0};  // resume from prescaler 0
    vecs[30] = '{3,  0, 0, 0, 0, 1, 1, 1, 0, 0};
    vecs[31] = '{1,  0, 0, 0, 0, 1, 1, 1, 1, 0};
    vecs[32] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[33] = '{1,  0, 0, 0, 0, 0, 0, 0, 0, 0};

    #3;
    chk("reset_async", pk(0, 3, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 34; i++)
      for (int r = 0; r < vecs[i].n; r++)
        step(vecs[i].st, vecs[i].pa, vecs[i].bo,
             pk(vecs[i].tens, vecs[i].ones, vecs[i].run, vecs[i].wrn, vecs[i].tick, vecs[i].tu),
             $sformatf("vec%0d.%0d", i, r));

    // Bonus on the final tick: 1 - 1 + 5 = 5, no expiry.
    step(1, 0, 0, pk(0, 0, 0, 0, 0, 0), "bt_start");
    for (int c = 0; c < 3; c++) step(0, 0, 0, pk(0, 3, 1, 0, 0, 0), "bt_c3");
    step(0, 0, 0, pk(0, 3, 1, 0, 1, 0), "bt_tick3");
    for (int c = 0; c < 3; c++) step(0, 0, 0, pk(0, 2, 1, 1, 0, 0), "bt_c2");
    step(0, 0, 0, pk(0, 2, 1, 1, 1, 0), "bt_tick2");
    for (int c = 0; c < 3; c++) step(0, 0, 0, pk(0, 1, 1, 1, 0, 0), "bt_c1");
    step(0, 0, 1, pk(0, 1, 1, 1, 1, 0), "bt_tick_bonus");
    for (int c = 0; c < 2; c++) step(0, 0, 0, pk(0, 5, 1, 0, 0, 0), "bt_after");

    // Saturation while paused: 5 + 18*5 = 95, then 95+5 -> 99, 99+5 -> 99.
    step(0, 1, 0, pk(0, 5, 1, 0, 0, 0), "sat_pause");
    for (int k = 0; k < 18; k++)
      step(0, 0, 1, pk((5 + 5 * k) / 10, (5 + 5 * k) % 10, 0, 0, 0, 0), "sat_add");
    step(0, 0, 1, pk(9, 5, 0, 0, 0, 0), "sat_95");
    step(0, 0, 1, pk(9, 9, 0, 0, 0, 0), "sat_99");
    step(0, 0, 0, pk(9, 9, 0, 0, 0, 0), "sat_hold");

    // Asynchronous reset in RUN at count 1.
    step(1, 0, 0, pk(9, 9, 0, 0, 0, 0), "ar_start");
    for (int c = 0; c < 3; c++) step(0, 0, 0, pk(0, 3, 1, 0, 0, 0), "ar_c3");
    step(0, 0, 0, pk(0, 3, 1, 0, 1, 0), "ar_tick3");
    for (int c = 0; c < 3; c++) step(0, 0, 0, pk(0, 2, 1, 1, 0, 0), "ar_c2");
    step(0, 0, 0, pk(0, 2, 1, 1, 1, 0), "ar_tick2");
    step(0, 0, 0, pk(0, 1, 1, 1, 0, 0), "ar_c1");
    start = 1'b0;
    #1 reset = 1'b1;
    #1 chk("ar_immediate", pk(0, 3, 0, 0, 0, 0));
    #1 reset = 1'b0;
    for (int c = 0; c < 8; c++) step(0, 0, 0, pk(0, 3, 0, 0, 0, 0), "ar_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
